// File: rtl/clmul_div_8bit.sv
// clmul_div_8bit: sequential GF(2) polynomial divider, the inverse of an
// N x N carry-less multiplier. Produces quotient and remainder such that
//   dividend = clmul(quotient, divisor) XOR remainder.
// One bit position of the dividend is processed per cycle, from the top
// down, so every job takes exactly 2N-1 cycles whatever the divisor.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   in_valid/in_ready    request handshake (accepted only in IDLE)
//   dividend [2N-2:0]    dividend polynomial, bit k = coeff of x^k
//   divisor  [N-1:0]     divisor polynomial
//   out_valid/out_ready  result handshake (results held until taken)
//   quotient [2N-2:0]    quotient polynomial
//   remainder[N-2:0]     remainder, degree < deg(divisor)
//   div_by_zero          divisor was zero (quotient/remainder forced 0)
//   check_err            internal re-multiply disagreed with the dividend
//
// Build option: define CLMUL_DIV_CHECK_EN to add a carry-less multiplier
// that re-checks each result on entry to DONE. Without it check_err is 0.
// Latency is identical in both builds.
module clmul_div_8bit #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-2:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-2:0]   quotient,
  output logic [N-2:0]     remainder,
  output logic             div_by_zero,
  output logic             check_err
);

  localparam int DW = 2*N-1;
  localparam int CW = $clog2(DW);
  localparam int GW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t          state, state_nxt;
  logic [DW-1:0]   r, q, r_nxt, q_nxt, d_ext;
  logic [N-1:0]    dsr;
  logic [CW-1:0]   idx, shift;
  logic [GW-1:0]   deg;
  logic            zero;
  logic            accept, last;

  // Position of the highest set bit; a zero input yields 0 and is handled
  // separately through the zero flag.
  function automatic logic [GW-1:0] degree(input logic [N-1:0] v);
    logic [GW-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      if (v[k]) g = k[GW-1:0];
    end
    return g;
  endfunction

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == '0);
  assign d_ext  = {{(DW-N){1'b0}}, dsr};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = DIV;
      DIV:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // One long-division step at position idx: cancel the leading term by
  // XORing in the divisor aligned so its top bit lands on idx.
  always_comb begin
    r_nxt = r;
    q_nxt = q;
    shift = idx - CW'(deg);
    if (!zero && (idx >= CW'(deg)) && r[idx]) begin
      r_nxt        = r ^ (d_ext << shift);
      q_nxt[shift] = 1'b1;
    end
  end

  // Working registers; they are only observable through the gated outputs,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      r    <= dividend;
      dsr  <= divisor;
      deg  <= degree(divisor);
      zero <= (divisor == '0);
      idx  <= CW'(DW-1);
      q    <= '0;
    end else if (state == DIV) begin
      r   <= r_nxt;
      q   <= q_nxt;
      idx <= idx - CW'(1);
    end
  end

`ifdef CLMUL_DIV_CHECK_EN
  logic [DW-1:0]     dvd;
  logic [DW+N-2:0]   prod;
  logic              mism, chk;

  function automatic logic [DW+N-2:0] clmul(input logic [DW-1:0] a,
                                            input logic [N-1:0]  b);
    logic [DW+N-2:0] p;
    logic [DW+N-2:0] ae;
    p  = '0;
    ae = {{(N-1){1'b0}}, a};
    for (int k = 0; k < N; k++) begin
      if (b[k]) p = p ^ (ae << k);
    end
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (accept) dvd <= dividend;
  end

  // Uses the values of the final step so the flag is ready with out_valid.
  always_comb begin
    prod = clmul(q_nxt, dsr) ^ {{(N-1){1'b0}}, r_nxt};
    mism = (prod != {{(N-1){1'b0}}, dvd});
  end

  always_ff @(posedge clk) begin
    if (rst)                         chk <= 1'b0;
    else if ((state == DIV) && last) chk <= mism && !zero;
  end

  assign check_err = (state == DONE) && chk;
`else
  assign check_err = 1'b0;
`endif

  // Output logic
  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    div_by_zero = (state == DONE) && zero;
    quotient    = '0;
    remainder   = '0;
    if ((state == DONE) && !zero) begin
      quotient  = q;
      remainder = r[N-2:0];
    end
  end

endmodule

// File: tb/tb_clmul_div_8bit.sv
module tb_clmul_div_8bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] quotient;
  logic [6:0]  remainder;
  logic        div_by_zero;
  logic        check_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clmul_div_8bit dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .check_err(check_err)
  );

  typedef struct {
    logic [14:0] dv;
    logic [7:0]  ds;
    logic [14:0] q;
    logic [6:0]  r;
    logic        dz;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] ref_clmul(input logic [14:0] a, input logic [7:0] b);
    logic [21:0] p;
    p = '0;
    for (int k = 0; k < 8; k++)
      if (b[k]) p = p ^ ({7'b0, a} << k);
    return p;
  endfunction

  function automatic int ref_deg(input logic [7:0] v);
    int g;
    g = 0;
    for (int k = 0; k < 8; k++) if (v[k]) g = k;
    return g;
  endfunction

  // Count clock edges until out_valid, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Present a request, wait for acceptance edge, return measured latency.
  task automatic start_job(input logic [14:0] dv, input logic [7:0] ds, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1; dividend = dv; divisor = ds;
    @(posedge clk); #1;
    in_valid = 0;
    wait_out(lat);
  endtask

  task automatic take_result;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    check("out_valid_after_take", out_valid, 0);
  endtask

  initial begin
    int lat;
    logic seen;
    logic [14:0] dv, hold_q;
    logic [7:0] ds;

    vecs[0] = '{15'h7FFF, 8'h03, 15'h2AAA, 7'h01, 1'b0};
    vecs[1] = '{15'h4000, 8'h80, 15'h0080, 7'h00, 1'b0};
    vecs[2] = '{15'h0005, 8'h03, 15'h0003, 7'h00, 1'b0};
    vecs[3] = '{15'h1234, 8'h01, 15'h1234, 7'h00, 1'b0};
    vecs[4] = '{15'h1234, 8'h00, 15'h0000, 7'h00, 1'b1};
    vecs[5] = '{15'h0003, 8'h05, 15'h0000, 7'h03, 1'b0};

    rst = 1; in_valid = 0; out_ready = 0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    check("rst_check_err", check_err, 0);

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      start_job(vecs[i].dv, vecs[i].ds, lat);
      check("latency", lat, 15);
      check("quotient", quotient, vecs[i].q);
      check("remainder", remainder, vecs[i].r);
      check("div_by_zero", div_by_zero, vecs[i].dz);
      check("check_err", check_err, 0);
      check("in_ready_in_done", in_ready, 0);
      take_result();
    end

    // Backpressure: hold results, ignore incoming requests
    start_job(15'h7FFF, 8'h03, lat);
    check("bp_latency", lat, 15);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1; dividend = 15'h0155; divisor = 8'h07;
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient", quotient, 15'h2AAA);
      check("bp_remainder", remainder, 7'h01);
      @(posedge clk); #1;
      in_valid = 0;
    end
    out_ready = 1; in_valid = 1; dividend = 15'h4000; divisor = 8'h80;
    @(posedge clk); #1;
    out_ready = 0;
    check("bp_release_out_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_next_accepted", in_ready, 0);
    wait_out(lat);
    check("bp_next_latency", lat, 15);
    check("bp_next_quotient", quotient, 15'h0080);
    check("bp_next_remainder", remainder, 0);
    take_result();

    // Reset in the middle of a division
    @(negedge clk);
    in_valid = 1; dividend = 15'h7FFF; divisor = 8'h03;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (7) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midrst_no_output", seen, 0);
    start_job(15'h0005, 8'h03, lat);
    check("midrst_fresh_latency", lat, 15);
    check("midrst_fresh_quotient", quotient, 15'h0003);
    check("midrst_fresh_remainder", remainder, 0);
    take_result();

    // Random jobs checked against the defining identity and remainder degree
    for (int n = 0; n < 200; n++) begin
      dv = 15'($urandom_range(0, 32767));
      ds = 8'($urandom_range(1, 255));
      start_job(dv, ds, lat);
      if (lat != 15) check("rnd_latency", lat, 15);
      check("rnd_identity", ref_clmul(quotient, ds) ^ {15'b0, remainder}, {7'b0, dv});
      check("rnd_rem_degree", {25'b0, remainder} >> ref_deg(ds), 0);
      check("rnd_check_err", check_err, 0);
      hold_q = quotient;
      take_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clmul_div_8bit.md
Name: clmul_div_8bit

Overview:
- Sequential GF(2) polynomial divider. It is the inverse of the combinational 8x8 carry-less multiplier that produces a 15-bit product.
- Takes a (2N-1)-bit dividend polynomial and an N-bit divisor polynomial. Returns quotient and remainder such that dividend = clmul(quotient, divisor) XOR remainder.
- Restores/decodes multiplier outputs in the arithmetic datapath; operates one bit position per cycle behind a valid/ready handshake.

Parameters:
- N, 8, operand width; dividend 2N-1 bits, quotient 2N-1 bits, remainder N-1 bits.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- dividend  input  2N-1  dividend polynomial, bit k = coeff of x^k.
- divisor  input  N  divisor polynomial.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  2N-1  quotient polynomial.
- remainder  output  N-1  remainder polynomial, degree < deg(divisor).
- div_by_zero  output  1  divisor was 0.
- check_err  output  1  self-check mismatch (see Optional Feature).

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; remainder=0; div_by_zero=0; check_err=0. Reset mid-operation aborts the job with no output.
- States: IDLE, DIV, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch dividend into working register R (2N-1 bits) and divisor into D;
  - compute d = deg(divisor) via priority encode of the highest set bit;
  - set counter i=2N-2; clear Q; go to DIV.
- DIV: in_ready=0. One iteration per cycle at position i:
  - if i>=d and R[i]=1, then R ^= D<<(i-d) and Q[i-d]=1;
  - decrement i.
  - After the iteration at i=0, go to DONE.
  - Exactly 2N-1 cycles (15 for N=8) regardless of divisor.
- DONE: out_valid=1; quotient=Q; remainder=R[N-2:0].
  - Outputs held stable until out_valid&out_ready, then go to IDLE.
  - in_ready=0 throughout DONE; there is no overlap of accept and deliver.
- Latency: handshake on edge E. out_valid is high from edge E+2N-1 (E+15); earliest new accept is the cycle after the output handshake.
- Divisor = 0: the block still runs the full 15 cycles. In DONE: div_by_zero=1, quotient=0, remainder=0.
- Divisor = 1 (d=0): quotient=dividend, remainder=0.
- Invariant: R bits at or above d are 0 at DONE, so the remainder truncation is lossless.
- in_valid while not IDLE is ignored; the input is not captured.
- out_ready while not DONE is ignored.

Optional Feature:
- Macro CLMUL_DIV_CHECK_EN.
- Defined:
  - on entry to DONE, register check_err = (clmul(Q, D) XOR {R}) != latched dividend, using an internal carry-less multiply;
  - forced 0 when div_by_zero=1;
  - check_err is valid with out_valid.
- Undefined: no multiplier is instantiated and check_err is tied 0.
- Latency is identical in both builds.

Test Plan:
- Reset, then dividend=0x7FFF, divisor=0x03 -> out_valid exactly 15 cycles after accept; quotient=0x2AAA, remainder=0x01, div_by_zero=0.
- dividend=0x4000, divisor=0x80 -> quotient=0x0080, remainder=0x00. Also dividend=0x0005, divisor=0x03 -> quotient=0x0003, remainder=0x00.
- dividend=0x1234, divisor=0x01 -> quotient=0x1234, remainder=0x00. Then divisor=0x00 -> div_by_zero=1, quotient=0, remainder=0, latency still 15.
- Backpressure: out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. The job after release is accepted only once back in IDLE.
- rst asserted at DIV cycle 7 -> next cycle shows the reset values, and out_valid never rises for the aborted job. A fresh request then completes correctly.
- With CLMUL_DIV_CHECK_EN: 200 random (dividend, nonzero divisor) pairs -> check_err=0 on every result, and the reference-model quotient/remainder match.
